// File: rtl/des_input_assembler.sv
// Byte-to-block assembler feeding the DES controller's data input.
// Bytes from the I2C slave are packed MSB-first into a fill register. A
// complete block moves into a hold register that drives data_in, so the next
// block can fill while the controller still owns the current one.
module des_input_assembler #(
  parameter int NUM_BYTES = 8,
  parameter int CNT_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  input  logic                   rx_abort,
  output logic                   rx_ready,
  input  logic                   next_data,
  input  logic                   clear_data,
  output logic [8*NUM_BYTES-1:0] data_in,
  output logic                   data_ready,
  output logic [CNT_W-1:0]       byte_count,
  output logic                   overflow
);

  localparam int W = 8 * NUM_BYTES;

  logic [W-1:0] fill;
  logic         fill_full;
  logic         accept;
  logic         transfer;
  logic         consume;
  logic         drop;

  // Decode of this cycle's events from the current state and inputs.
  assign fill_full = (byte_count == CNT_W'(NUM_BYTES));
  assign rx_ready  = !fill_full;
  assign accept    = rx_valid && rx_ready && !rx_abort;
  assign transfer  = fill_full && (!data_ready || next_data);
  assign consume   = next_data && data_ready && !transfer;
  assign drop      = rx_valid && !rx_ready && !rx_abort;

  // Fill register, byte counter, hold register and sticky overflow flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill       <= '0;
      byte_count <= '0;
      data_in    <= '0;
      data_ready <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear_data) begin
      // Flush: the same-cycle byte, abort and next_data are all ignored.
      byte_count <= '0;
      data_in    <= '0;
      data_ready <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end

      // Abort only discards a partial block; a complete one is kept.
      if (rx_abort && !fill_full) begin
        byte_count <= '0;
      end

      if (transfer) begin
        data_in    <= fill;
        data_ready <= 1'b1;
        byte_count <= '0;
      end else if (consume) begin
        data_ready <= 1'b0;
      end

      // accept implies !fill_full, so it never collides with transfer.
      if (accept) begin
        fill       <= {fill[W-9:0], rx_byte};
        byte_count <= byte_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_des_input_assembler.sv
// Self-checking bench for des_input_assembler: a queue-based reference model
// is compared against the DUT every cycle, with literal checks at key points.
module tb_des_input_assembler;

  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic        rx_abort = 1'b0;
  logic        rx_ready;
  logic        next_data = 1'b0;
  logic        clear_data = 1'b0;
  logic [63:0] data_in;
  logic        data_ready;
  logic [3:0]  byte_count;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [7:0]  m_q[$];
  logic [63:0] m_hold = '0;
  bit          m_rdy  = 1'b0;
  bit          m_ovf  = 1'b0;

  des_input_assembler #(.NUM_BYTES(NB), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_abort   (rx_abort),
    .rx_ready   (rx_ready),
    .next_data  (next_data),
    .clear_data (clear_data),
    .data_in    (data_in),
    .data_ready (data_ready),
    .byte_count (byte_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: block-level rules applied at each rising edge.
  always @(posedge clk) begin
    bit full;
    full = (m_q.size() == NB);
    if (rst) begin
      m_q.delete();
      m_hold = '0;
      m_rdy  = 1'b0;
      m_ovf  = 1'b0;
    end else if (clear_data) begin
      m_q.delete();
      m_hold = '0;
      m_rdy  = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      if (rx_valid && full && !rx_abort) m_ovf = 1'b1;
      if (rx_abort && !full) m_q.delete();
      if (full && (!m_rdy || next_data)) begin
        m_hold = '0;
        foreach (m_q[i]) m_hold = m_hold * 256 + 64'(m_q[i]);
        m_q.delete();
        m_rdy = 1'b1;
      end else if (next_data && m_rdy) begin
        m_rdy = 1'b0;
      end
      if (rx_valid && !full && !rx_abort) m_q.push_back(rx_byte);
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_data_in",    data_in,    m_hold);
      check("cyc_data_ready", 64'(data_ready), 64'(m_rdy));
      check("cyc_byte_count", 64'(byte_count), 64'(m_q.size()));
      check("cyc_overflow",   64'(overflow),   64'(m_ovf));
      check("cyc_rx_ready",   64'(rx_ready),   64'(m_q.size() != NB));
    end
  end

  task automatic cyc(input bit v, input logic [7:0] b, input bit a,
                     input bit n, input bit c, input bit r);
    rx_valid   = v;
    rx_byte    = b;
    rx_abort   = a;
    next_data  = n;
    clear_data = c;
    rst        = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_n(input logic [63:0] blk, input int n);
    for (int i = 0; i < n; i++) send(blk[63-8*i -: 8]);
  endtask

  initial begin
    // 1. Reset, then one block, data_ready one edge after the last byte.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    check("rst_data_in", data_in, 64'h0);
    check("rst_data_ready", 64'(data_ready), 64'h0);
    check("rst_byte_count", 64'(byte_count), 64'h0);
    check("rst_overflow", 64'(overflow), 64'h0);
    check("rst_rx_ready", 64'(rx_ready), 64'h1);
    send_n(64'h1234567890abcdef, 8);
    check("t1_full_count", 64'(byte_count), 64'd8);
    check("t1_not_yet_ready", 64'(data_ready), 64'h0);
    idle();
    check("t1_ready", 64'(data_ready), 64'h1);
    check("t1_data_in", data_in, 64'h1234567890abcdef);
    check("t1_count0", 64'(byte_count), 64'h0);

    // 2. Stall with hold occupied, overflow, then transfer on next_data.
    send_n(64'hfedcba9876543210, 8);
    check("t2_count8", 64'(byte_count), 64'd8);
    check("t2_rx_ready0", 64'(rx_ready), 64'h0);
    idle();
    check("t2_hold_kept", data_in, 64'h1234567890abcdef);
    send(8'h55);
    check("t2_overflow", 64'(overflow), 64'h1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t2_data_in_b", data_in, 64'hfedcba9876543210);
    check("t2_ready_stays", 64'(data_ready), 64'h1);
    check("t2_rx_ready1", 64'(rx_ready), 64'h1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t2_consumed", 64'(data_ready), 64'h0);

    // 3. Abort alone, then abort together with a byte.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    send_n(64'haabbcc0000000000, 3);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_abort_count", 64'(byte_count), 64'h0);
    send_n(64'h0102030405060708, 8);
    idle();
    check("t3_data_in", data_in, 64'h0102030405060708);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    send_n(64'h2122230000000000, 3);
    cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_abort_v_count", 64'(byte_count), 64'h0);
    check("t3_abort_v_ovf", 64'(overflow), 64'h0);
    send_n(64'h1112131415161718, 8);
    idle();
    check("t3_data_in2", data_in, 64'h1112131415161718);

    // 4. clear_data with partial fill, overflow and held block.
    send_n(64'h3132333435363738, 8);
    send(8'h77);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    send_n(64'h4142434445000000, 5);
    check("t4_pre_count", 64'(byte_count), 64'd5);
    check("t4_pre_ovf", 64'(overflow), 64'h1);
    cyc(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_count", 64'(byte_count), 64'h0);
    check("t4_ready", 64'(data_ready), 64'h0);
    check("t4_data_in", data_in, 64'h0);
    check("t4_ovf", 64'(overflow), 64'h0);

    // 5. next_data ignored when empty; consume with a partial fill.
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_ignored", 64'(data_ready), 64'h0);
    send_n(64'h5152535455565758, 8);
    idle();
    send_n(64'h6162636400000000, 4);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_ready0", 64'(data_ready), 64'h0);
    check("t5_data_kept", data_in, 64'h5152535455565758);
    check("t5_count4", 64'(byte_count), 64'd4);

    // 6. Reset mid-block, then a fresh block.
    send_n(64'h6566676800000000, 4);
    idle();
    send_n(64'h7172737475760000, 6);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_data_in", data_in, 64'h0);
    check("t6_ready", 64'(data_ready), 64'h0);
    check("t6_count", 64'(byte_count), 64'h0);
    send_n(64'h8182838485868788, 8);
    idle();
    check("t6_fresh", data_in, 64'h8182838485868788);
    check("t6_fresh_ready", 64'(data_ready), 64'h1);

    idle();
    idle();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
